// File: rtl/bcd_to_binary_seq.sv
// bcd_to_binary_seq: sequential 3-digit BCD to 10-bit binary converter.
// Uses reverse double-dabble, one iteration per clock, 10 iterations per
// operand. An operand containing a digit above 9 is rejected at once
// with err=1 and a done strobe, without entering the shift phase.
module bcd_to_binary_seq (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [9:0]  bin_out
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [11:0] r_digits;
    logic [9:0]  r_acc;
    logic [3:0]  r_cnt;
    logic        r_done;
    logic        r_err;
    logic [9:0]  r_bin;

    logic        w_accept;
    logic        w_last;
    logic        w_bad;
    logic [21:0] w_step;

    // True when any BCD nibble holds a value above 9.
    function automatic logic f_bad_bcd(input logic [11:0] b);
        logic bad;
        bad = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (b[4*k +: 4] > 4'd9) begin
                bad = 1'b1;
            end
        end
        return bad;
    endfunction

    // One reverse double-dabble iteration: shift {digits, acc} right,
    // then correct every digit nibble that came out at 8 or more.
    function automatic logic [21:0] f_dabble(input logic [21:0] v);
        logic [21:0] s;
        s = v >> 1;
        for (int k = 0; k < 3; k++) begin
            if (s[10 + 4*k +: 4] >= 4'd8) begin
                s[10 + 4*k +: 4] = s[10 + 4*k +: 4] - 4'd3;
            end
        end
        return s;
    endfunction

    assign w_bad  = f_bad_bcd(bcd_in);
    assign w_step = f_dabble({r_digits, r_acc});

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic plus accept / last-iteration decodes.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    if (!w_bad) begin
                        w_state_nxt = SHIFT;
                    end
                end
            end
            SHIFT: begin
                // Counter counts completed iterations; 9 means this edge is the 10th.
                if (r_cnt == 4'd9) begin
                    w_last      = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, iteration, result and status registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_digits <= 12'd0;
            r_acc    <= 10'd0;
            r_cnt    <= 4'd0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_bin    <= 10'd0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_digits <= bcd_in;
                r_acc    <= 10'd0;
                r_cnt    <= 4'd0;
                if (w_bad) begin
                    r_err  <= 1'b1;
                    r_bin  <= 10'd0;
                    r_done <= 1'b1;
                end else begin
                    r_err  <= 1'b0;
                end
            end else if (r_state == SHIFT) begin
                {r_digits, r_acc} <= w_step;
                r_cnt             <= r_cnt + 4'd1;
                if (w_last) begin
                    r_bin  <= w_step[9:0];
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign busy    = (r_state == SHIFT);
    assign done    = r_done;
    assign err     = r_err;
    assign bin_out = r_bin;

endmodule

// File: tb/tb_bcd_to_binary_seq.sv
// Testbench for bcd_to_binary_seq: transaction-level decimal model checked
// every cycle, plus directed vectors with hand-computed results.
module tb_bcd_to_binary_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [11:0] bcd_in;
    logic        busy;
    logic        done;
    logic        err;
    logic [9:0]  bin_out;

    int checks = 0;
    int errors = 0;
    int n_done = 0;

    bcd_to_binary_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .bcd_in  (bcd_in),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .bin_out (bin_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int dec(input logic [11:0] b);
        return int'(b[11:8]) * 100 + int'(b[7:4]) * 10 + int'(b[3:0]);
    endfunction

    function automatic bit is_bad(input logic [11:0] b);
        return (b[11:8] > 9) || (b[7:4] > 9) || (b[3:0] > 9);
    endfunction

    // Behavioural model: idle/busy with a remaining-cycle count and the
    // decimal value of the operand in flight.
    bit m_busy;
    int m_left;
    int m_val;
    bit m_done;
    bit m_err;
    int m_bin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_left <= 0; m_val <= 0;
            m_done <= 0; m_err <= 0; m_bin <= 0;
        end else begin
            m_done <= 0;
            if (!m_busy) begin
                if (start) begin
                    if (is_bad(bcd_in)) begin
                        m_err  <= 1;
                        m_bin  <= 0;
                        m_done <= 1;
                    end else begin
                        m_busy <= 1;
                        m_left <= 10;
                        m_val  <= dec(bcd_in);
                        m_err  <= 0;
                    end
                end
            end else begin
                if (m_left == 1) begin
                    m_busy <= 0;
                    m_bin  <= m_val;
                    m_done <= 1;
                end
                m_left <= m_left - 1;
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("busy", int'(busy), int'(m_busy));
        chk("done", int'(done), int'(m_done));
        chk("err", int'(err), int'(m_err));
        chk("bin_out", int'(bin_out), m_bin);
        if (done) n_done++;
    end

    task automatic convert(input logic [11:0] b, input int exp_bin, input int exp_err, input string nm);
        int lat;
        int busy_seen;
        @(posedge clk); #2;
        start  = 1'b1;
        bcd_in = b;
        @(posedge clk);
        #1;
        start  = 1'b0;
        bcd_in = 12'($urandom);
        lat = 0;
        busy_seen = int'(busy);
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (busy) busy_seen = 1;
        end
        chk({nm, "_latency"}, lat, (exp_err != 0) ? 0 : 10);
        chk({nm, "_bin"}, int'(bin_out), exp_bin);
        chk({nm, "_err"}, int'(err), exp_err);
        chk({nm, "_busy_seen"}, busy_seen, (exp_err != 0) ? 0 : 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int n0;
        logic [11:0] b;

        rst_n  = 1'b0;
        start  = 1'b0;
        bcd_in = 12'd0;
        #1;
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_bin", int'(bin_out), 0);
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;

        // Directed vectors.
        convert(12'h999, 999, 0, "v999");
        convert(12'h000, 0, 0, "v000");
        convert(12'h255, 255, 0, "v255");
        convert(12'h100, 100, 0, "v100");
        convert(12'h1A3, 0, 1, "v1A3");
        convert(12'h00F, 0, 1, "v00F");
        convert(12'h909, 909, 0, "v909");

        // Start during busy is ignored.
        @(posedge clk); #2;
        start = 1'b1; bcd_in = 12'h512;
        n0 = n_done;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1 start = 1'b1; bcd_in = 12'h999;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("ignore_bin", int'(bin_out), 512);
        repeat (3) @(posedge clk);
        #1 chk("ignore_done_count", n_done - n0, 1);

        // Back-to-back: start held during the done cycle.
        @(posedge clk); #2;
        start = 1'b1; bcd_in = 12'h042;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("b2b_first_bin", int'(bin_out), 42);
        start = 1'b1; bcd_in = 12'h123;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(lat);
        chk("b2b_second_lat", lat, 10);
        chk("b2b_second_bin", int'(bin_out), 123);

        // Reset in the middle of a conversion.
        @(posedge clk); #2;
        start = 1'b1; bcd_in = 12'h777;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("abort_busy", int'(busy), 0);
        chk("abort_done", int'(done), 0);
        chk("abort_err", int'(err), 0);
        chk("abort_bin", int'(bin_out), 0);
        n0 = n_done;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1 chk("abort_no_done", n_done - n0, 0);
        convert(12'h777, 777, 0, "v777_after_reset");

        // Random single conversions.
        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                b = 12'($urandom);
            end else begin
                b = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
            convert(b, is_bad(b) ? 0 : dec(b), is_bad(b) ? 1 : 0, "rand");
            repeat ($urandom_range(0, 2)) @(posedge clk);
        end

        // Free-running random start/operand traffic, checked by the model.
        for (int i = 0; i < 150; i++) begin
            @(posedge clk); #2;
            start = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
                bcd_in = 12'($urandom);
            end else begin
                bcd_in = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end
        end
        start = 1'b0;
        repeat (15) @(posedge clk);
        #1;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
